id_stage_pipe: RTL and testbench

- Registered, handshaked decode stage for the integer pipeline, between IF and EX.
- Decodes the RV64I integer-ALU subset: OP-IMM, OP, OP-IMM-32, OP-32, LUI, AUIPC.
- Emits register-file read/write controls, a sign-extended immediate, ALU operand selects and ALU control.
- Replaces the single-instruction, combinational-only decoder (ADDI) with a parametrised, one-entry pipeline stage that supports valid/ready and flush.

---
 rtl/id_stage_pipe_pkg.sv | 38 +++
 rtl/id_stage_pipe_decode_comb.sv | 124 ++++++++++++
 rtl/id_stage_pipe.sv | 128 ++++++++++++
 tb/tb_id_stage_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/id_stage_pipe_pkg.sv
// Shared definitions for the integer decode stage: opcode constants,
// ALU control encodings, and the decoded-control bundle layout.
package id_stage_pipe_pkg;

    localparam int XLEN_DEF = 64;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;
    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;

    // {alt, funct3}; alt is set only for SUB / SRA / SRAI
    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_ctl_e;

    typedef struct packed {
        logic     ra_en;
        logic     rb_en;
        logic     rd_en;
        logic     alu_asrc;
        logic     alu_bsrc;
        logic     alu_word;
        alu_ctl_e alu_ctl;
    } id_ctrl_t;

endpackage

// File: rtl/id_stage_pipe_decode_comb.sv
// Pure combinational RV64I integer-ALU decoder (OP-IMM, OP, *-32, LUI, AUIPC).
// Illegal words come out as an all-zero NOP bundle.
// ID_ILLEGAL_TRAP_EN: exposes the illegal flag as o_illegal.
module id_decode_comb
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ILEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic [ILEN-1:0]   i_inst,
    output id_ctrl_t          o_ctrl,
    output logic [REG_AW-1:0] o_ra_addr,
    output logic [REG_AW-1:0] o_rb_addr,
    output logic [REG_AW-1:0] o_rd_addr,
    output logic [XLEN-1:0]   o_imm
`ifdef ID_ILLEGAL_TRAP_EN
    ,
    output logic              o_illegal
`endif
);

    logic [6:0]         w_opc;
    logic [2:0]         w_f3;
    logic [6:0]         w_f7;
    logic [5:0]         w_f6;
    logic signed [11:0] w_imm_i;
    logic signed [31:0] w_imm_u;
    logic               w_legal;
    logic               w_alt;
    id_ctrl_t           w_ctrl;
    logic [XLEN-1:0]    w_imm;

    assign w_opc   = i_inst[6:0];
    assign w_f3    = i_inst[14:12];
    assign w_f7    = i_inst[31:25];
    assign w_f6    = i_inst[31:26];
    assign w_imm_i = i_inst[31:20];
    assign w_imm_u = {i_inst[31:12], 12'b0};

    // opcode/funct legality check and control generation; illegal collapses to NOP
    always_comb begin
        w_ctrl  = '0;
        w_imm   = '0;
        w_legal = 1'b0;
        w_alt   = 1'b0;
        case (w_opc)
            OP_IMM: begin
                w_legal         = 1'b1;
                w_ctrl.ra_en    = 1'b1;
                w_ctrl.alu_bsrc = 1'b1;
                w_imm           = XLEN'(w_imm_i);
                // 6-bit shamt on RV64; on RV32 shamt[5] must be clear
                if (w_f3 == 3'b001) begin
                    w_legal = (w_f6 == 6'b000000) && (XLEN == 64 || !i_inst[25]);
                end else if (w_f3 == 3'b101) begin
                    w_legal = (w_f6 == 6'b000000 || w_f6 == 6'b010000) &&
                              (XLEN == 64 || !i_inst[25]);
                    w_alt   = i_inst[30];
                end
            end
            OP: begin
                w_ctrl.ra_en = 1'b1;
                w_ctrl.rb_en = 1'b1;
                if (w_f7 == 7'b0000000) begin
                    w_legal = 1'b1;
                end else if (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)) begin
                    w_legal = 1'b1;
                    w_alt   = 1'b1;
                end
            end
            OP_IMM_32: begin
                w_ctrl.ra_en    = 1'b1;
                w_ctrl.alu_bsrc = 1'b1;
                w_ctrl.alu_word = 1'b1;
                w_imm           = XLEN'(w_imm_i);
                case (w_f3)
                    3'b000:  w_legal = 1'b1;
                    3'b001:  w_legal = (w_f7 == 7'b0000000);
                    3'b101: begin
                        w_legal = (w_f7 == 7'b0000000 || w_f7 == 7'b0100000);
                        w_alt   = i_inst[30];
                    end
                    default: w_legal = 1'b0;
                endcase
                if (XLEN != 64) w_legal = 1'b0;
            end
            OP_32: begin
                w_ctrl.ra_en    = 1'b1;
                w_ctrl.rb_en    = 1'b1;
                w_ctrl.alu_word = 1'b1;
                w_alt           = w_f7[5];
                w_legal = (w_f3 == 3'b000 || w_f3 == 3'b001 || w_f3 == 3'b101) &&
                          (w_f7 == 7'b0000000 || (w_f7 == 7'b0100000 && w_f3 != 3'b001)) &&
                          (XLEN == 64);
            end
            LUI, AUIPC: begin
                w_legal         = 1'b1;
                w_ctrl.alu_bsrc = 1'b1;
                w_ctrl.alu_asrc = (w_opc == AUIPC);
                w_imm           = XLEN'(w_imm_u);
            end
            default: w_legal = 1'b0;
        endcase
        w_ctrl.rd_en   = 1'b1;
        w_ctrl.alu_ctl = (w_opc == LUI || w_opc == AUIPC) ? ALU_ADD
                                                          : alu_ctl_e'({w_alt, w_f3});
        if (!w_legal) begin
            w_ctrl = '0;
            w_imm  = '0;
        end
    end

    assign o_ctrl    = w_ctrl;
    assign o_imm     = w_imm;
    // ra_en is low only for LUI/AUIPC and NOPs, both of which want ra_addr=0
    assign o_ra_addr = w_ctrl.ra_en ? REG_AW'(i_inst[19:15]) : '0;
    assign o_rb_addr = w_legal ? REG_AW'(i_inst[24:20]) : '0;
    assign o_rd_addr = w_legal ? REG_AW'(i_inst[11:7])  : '0;
`ifdef ID_ILLEGAL_TRAP_EN
    assign o_illegal = !w_legal;
`endif

endmodule

// File: rtl/id_stage_pipe.sv
// Registered, valid/ready decode stage between IF and EX: one-entry output
// register around id_decode_comb, with flush.
// ID_ILLEGAL_TRAP_EN: adds out_illegal and out_inst (raw word for trap value).
module id_stage_pipe
    import id_stage_pipe_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int ILEN   = 32,
    parameter int REG_AW = 5,
    parameter int PC_W   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ILEN-1:0]   in_inst,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PC_W-1:0]   out_pc,
    output logic              ra_en,
    output logic [REG_AW-1:0] ra_addr,
    output logic              rb_en,
    output logic [REG_AW-1:0] rb_addr,
    output logic              rd_en,
    output logic [REG_AW-1:0] rd_addr,
    output logic [XLEN-1:0]   imm,
    output logic              alu_asrc,
    output logic              alu_bsrc,
    output logic              alu_word,
    output logic [3:0]        alu_ctl
`ifdef ID_ILLEGAL_TRAP_EN
    ,
    output logic              out_illegal,
    output logic [ILEN-1:0]   out_inst
`endif
);

    id_ctrl_t          w_ctrl;
    logic [REG_AW-1:0] w_ra_addr, w_rb_addr, w_rd_addr;
    logic [XLEN-1:0]   w_imm;
    logic              w_load;

    id_ctrl_t          r_ctrl;
    logic              r_valid;
    logic [PC_W-1:0]   r_pc;
    logic [REG_AW-1:0] r_ra_addr, r_rb_addr, r_rd_addr;
    logic [XLEN-1:0]   r_imm;
`ifdef ID_ILLEGAL_TRAP_EN
    logic              w_illegal;
    logic              r_illegal;
    logic [ILEN-1:0]   r_inst;
`endif

    id_decode_comb #(
        .XLEN   (XLEN),
        .ILEN   (ILEN),
        .REG_AW (REG_AW)
    ) u_dec (
        .i_inst    (in_inst),
        .o_ctrl    (w_ctrl),
        .o_ra_addr (w_ra_addr),
        .o_rb_addr (w_rb_addr),
        .o_rd_addr (w_rd_addr),
        .o_imm     (w_imm)
`ifdef ID_ILLEGAL_TRAP_EN
        ,
        .o_illegal (w_illegal)
`endif
    );

    // free slot or the held entry leaves this cycle; independent of in_valid and flush
    assign in_ready = !r_valid || out_ready;
    assign w_load   = in_valid && in_ready && !flush;

    // entry register: flush beats load beats drain; hold otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_ctrl    <= '0;
            r_pc      <= '0;
            r_ra_addr <= '0;
            r_rb_addr <= '0;
            r_rd_addr <= '0;
            r_imm     <= '0;
`ifdef ID_ILLEGAL_TRAP_EN
            r_illegal <= 1'b0;
            r_inst    <= '0;
`endif
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid   <= 1'b1;
            r_ctrl    <= w_ctrl;
            r_pc      <= in_pc;
            r_ra_addr <= w_ra_addr;
            r_rb_addr <= w_rb_addr;
            r_rd_addr <= w_rd_addr;
            r_imm     <= w_imm;
`ifdef ID_ILLEGAL_TRAP_EN
            r_illegal <= w_illegal;
            r_inst    <= in_inst;
`endif
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid = r_valid;
    assign out_pc    = r_pc;
    assign ra_en     = r_ctrl.ra_en;
    assign rb_en     = r_ctrl.rb_en;
    assign rd_en     = r_ctrl.rd_en;
    assign alu_asrc  = r_ctrl.alu_asrc;
    assign alu_bsrc  = r_ctrl.alu_bsrc;
    assign alu_word  = r_ctrl.alu_word;
    assign alu_ctl   = r_ctrl.alu_ctl;
    assign ra_addr   = r_ra_addr;
    assign rb_addr   = r_rb_addr;
    assign rd_addr   = r_rd_addr;
    assign imm       = r_imm;
`ifdef ID_ILLEGAL_TRAP_EN
    assign out_illegal = r_illegal;
    assign out_inst    = r_inst;
`endif

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: decode vector table streamed back-to-back,
// then stall, flush and asynchronous-reset sequences.
// ID_ILLEGAL_TRAP_EN: also checks out_illegal / out_inst.
module tb_id_stage_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_inst = '0;
    logic [63:0] in_pc = '0;
    logic        in_ready, out_valid;
    logic [63:0] out_pc, imm;
    logic        ra_en, rb_en, rd_en, alu_asrc, alu_bsrc, alu_word;
    logic [4:0]  ra_addr, rb_addr, rd_addr;
    logic [3:0]  alu_ctl;
`ifdef ID_ILLEGAL_TRAP_EN
    logic        out_illegal;
    logic [31:0] out_inst;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_stage_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_inst   (in_inst),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .ra_en     (ra_en),
        .ra_addr   (ra_addr),
        .rb_en     (rb_en),
        .rb_addr   (rb_addr),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .imm       (imm),
        .alu_asrc  (alu_asrc),
        .alu_bsrc  (alu_bsrc),
        .alu_word  (alu_word),
        .alu_ctl   (alu_ctl)
`ifdef ID_ILLEGAL_TRAP_EN
        ,
        .out_illegal (out_illegal),
        .out_inst    (out_inst)
`endif
    );

    typedef struct packed {
        logic        v, ra_en, rb_en, rd_en;
        logic [4:0]  ra, rb, rd;
        logic [63:0] imm;
        logic        asrc, bsrc, word;
        logic [3:0]  ctl;
    } obs_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        obs_t        exp;
        logic        ill;
    } vec_t;

    localparam int NV = 18;
    vec_t vec[NV];

    function automatic obs_t mk(input logic v, ra_e, rb_e, rd_e, input logic [4:0] ra, rb, rd,
                                input logic [63:0] im, input logic as, bs, wd,
                                input logic [3:0] ctl);
        obs_t o;
        o = '{v, ra_e, rb_e, rd_e, ra, rb, rd, im, as, bs, wd, ctl};
        return o;
    endfunction

    function automatic obs_t got();
        obs_t o;
        o = '{out_valid, ra_en, rb_en, rd_en, ra_addr, rb_addr, rd_addr, imm,
              alu_asrc, alu_bsrc, alu_word, alu_ctl};
        return o;
    endfunction

    // illegal words: only valid, enables and alu_ctl are pinned down
    function automatic obs_t nop_mask(input obs_t o);
        obs_t m;
        m = '0;
        m.v = o.v; m.ra_en = o.ra_en; m.rb_en = o.rb_en; m.rd_en = o.rd_en; m.ctl = o.ctl;
        return m;
    endfunction

    task automatic chk(input string nm, input logic [127:0] g, input logic [127:0] e);
        n_tests++;
        if (g !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, g, e);
        end
    endtask

    task automatic drive(input logic [31:0] inst, input logic [63:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    obs_t e_addi, e_sub, e_auipc, zero_obs;

    initial begin
        vec[0]  = '{"addi -1",    32'hFFF10093, mk(1,1,0,1, 2,31,1, 64'hFFFF_FFFF_FFFF_FFFF, 0,1,0, 4'b0000), 1'b0};
        vec[1]  = '{"sub",        32'h405201B3, mk(1,1,1,1, 4, 5,3, 64'h0,                   0,0,0, 4'b1000), 1'b0};
        vec[2]  = '{"sraiw",      32'h4033531B, mk(1,1,0,1, 6, 3,6, 64'h403,                 0,1,1, 4'b1101), 1'b0};
        vec[3]  = '{"srai 63",    32'h43F15093, mk(1,1,0,1, 2,31,1, 64'h43F,                 0,1,0, 4'b1101), 1'b0};
        vec[4]  = '{"sltiu min",  32'h80033293, mk(1,1,0,1, 6, 0,5, 64'hFFFF_FFFF_FFFF_F800, 0,1,0, 4'b0011), 1'b0};
        vec[5]  = '{"subw",       32'h403100BB, mk(1,1,1,1, 2, 3,1, 64'h0,                   0,0,1, 4'b1000), 1'b0};
        vec[6]  = '{"lui",        32'h123453B7, mk(1,0,0,1, 0, 3,7, 64'h1234_5000,           0,1,0, 4'b0000), 1'b0};
        vec[7]  = '{"lui neg",    32'h800000B7, mk(1,0,0,1, 0, 0,1, 64'hFFFF_FFFF_8000_0000, 0,1,0, 4'b0000), 1'b0};
        vec[8]  = '{"auipc",      32'h00001397, mk(1,0,0,1, 0, 0,7, 64'h1000,                1,1,0, 4'b0000), 1'b0};
        vec[9]  = '{"ill ones",   32'hFFFFFFFF, mk(1,0,0,0, 0, 0,0, 64'h0,                   0,0,0, 4'b0000), 1'b1};
        vec[10] = '{"slliw sh32", 32'h0201109B, mk(1,0,0,0, 0, 0,0, 64'h0,                   0,0,0, 4'b0000), 1'b1};
        vec[11] = '{"or alt",     32'h40316033, mk(1,0,0,0, 0, 0,0, 64'h0,                   0,0,0, 4'b0000), 1'b1};
        vec[12] = '{"opimm32 f3", 32'h0001209B, mk(1,0,0,0, 0, 0,0, 64'h0,                   0,0,0, 4'b0000), 1'b1};
        vec[13] = '{"slli 63",    32'h03F11093, mk(1,1,0,1, 2,31,1, 64'h3F,                  0,1,0, 4'b0001), 1'b0};
        vec[14] = '{"xor",        32'h00C5C533, mk(1,1,1,1,11,12,10, 64'h0,                  0,0,0, 4'b0100), 1'b0};
        vec[15] = '{"sra",        32'h403150B3, mk(1,1,1,1, 2, 3,1, 64'h0,                   0,0,0, 4'b1101), 1'b0};
        vec[16] = '{"slli alt",   32'h40111093, mk(1,0,0,0, 0, 0,0, 64'h0,                   0,0,0, 4'b0000), 1'b1};
        vec[17] = '{"addi 0x400", 32'h40000093, mk(1,1,0,1, 0, 0,1, 64'h400,                 0,1,0, 4'b0000), 1'b0};
        e_addi   = vec[0].exp;
        e_sub    = vec[1].exp;
        e_auipc  = vec[8].exp;
        zero_obs = '0;

        // reset state
        #1;
        chk("reset outputs", 128'(got()), 128'(zero_obs));
        chk("reset pc", 128'(out_pc), 128'(0));
        chk("reset in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // table streamed back-to-back with out_ready=1: each entry must appear
        // exactly one cycle after it was presented
        out_ready = 1'b1;
        drive(vec[0].inst, 64'h1000);
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            if (vec[i].ill)
                chk({vec[i].name, " dec"}, 128'(nop_mask(got())), 128'(nop_mask(vec[i].exp)));
            else
                chk({vec[i].name, " dec"}, 128'(got()), 128'(vec[i].exp));
            chk({vec[i].name, " pc"}, 128'(out_pc), 128'(64'h1000 + 64'(4 * i)));
`ifdef ID_ILLEGAL_TRAP_EN
            chk({vec[i].name, " illegal"}, 128'(out_illegal), 128'(vec[i].ill));
            chk({vec[i].name, " inst"}, 128'(out_inst), 128'(vec[i].inst));
`endif
            if (i + 1 < NV) drive(vec[i + 1].inst, 64'h1000 + 64'(4 * (i + 1)));
            else in_valid = 1'b0;
        end
        @(negedge clk);
        chk("drain valid", 128'(out_valid), 128'(0));

        // stall: ADDI held for 3 cycles while SUB waits at the input
        drive(vec[0].inst, 64'h2000);
        @(negedge clk);
        drive(vec[1].inst, 64'h2004);
        out_ready = 1'b0;
        #1;
        chk("stall in_ready", 128'(in_ready), 128'(0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall hold", 128'(got()), 128'(e_addi));
            chk("stall pc", 128'(out_pc), 128'(64'h2000));
            chk("stall in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        #1;
        chk("unstall in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        chk("queued sub", 128'(got()), 128'(e_sub));
        chk("queued pc", 128'(out_pc), 128'(64'h2004));
        in_valid = 1'b0;

        // flush in the same cycle as an accept of LUI drops it
        drive(vec[6].inst, 64'h3000);
        flush = 1'b1;
        #1;
        chk("flush in_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        flush = 1'b0;
        chk("flush valid", 128'(out_valid), 128'(0));
        drive(vec[8].inst, 64'h3004);
        @(negedge clk);
        chk("post-flush auipc", 128'(got()), 128'(e_auipc));
        chk("post-flush pc", 128'(out_pc), 128'(64'h3004));
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("held auipc", 128'(got()), 128'(e_auipc));
        // flush also squashes an entry being held by EX backpressure
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush held", 128'(out_valid), 128'(0));

        // asynchronous reset in the middle of a stall
        out_ready = 1'b1;
        drive(vec[0].inst, 64'h4000);
        @(negedge clk);
        out_ready = 1'b0;
        drive(vec[1].inst, 64'h4004);
        #1;
        chk("pre-reset held", 128'(got()), 128'(e_addi));
        #1;
        rst_n = 1'b0;
        #1;
        chk("async reset outputs", 128'(got()), 128'(zero_obs));
        chk("async reset pc", 128'(out_pc), 128'(0));
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("post-reset in_ready", 128'(in_ready), 128'(1));
        chk("post-reset valid", 128'(out_valid), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
